// File: rtl/key_event_queue.sv
// Keypad event queue: edge-detects presses, classifies them against operand context,
// limits digits per operand and buffers accepted events in a valid/ready FIFO.
module key_event_queue #(
    parameter int KEY_W      = 5,
    parameter int DEPTH      = 4,
    parameter int MAX_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     validPress,
    input  logic [KEY_W-1:0]         button,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [2:0]               ev_class,
    output logic [KEY_W-1:0]         ev_code,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int ENT_W = 3 + KEY_W;

    typedef enum logic [2:0] {
        START,
        NEG,
        IN_OP,
        AFTER_OP,
        RESULT
    } ctxState_t;

    typedef enum logic [2:0] {
        CLS_NONE     = 3'd0,
        CLS_NUMBER   = 3'd1,
        CLS_OPER     = 3'd2,
        CLS_NEGATIVE = 3'd3,
        CLS_EQUAL    = 3'd4,
        CLS_CLEAR    = 3'd5
    } evClass_t;

    ctxState_t               state, stateNext;
    logic [CNT_W-1:0]        digitCnt, digitCntNext;
    logic                    prevPress;
    logic                    press;

    logic [ENT_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]        rdPtr, wrPtr;
    logic [$clog2(DEPTH):0]  count;

    logic                    isDigit, isMinus, isOp, isEqual, isClear;
    logic                    clearPress;
    logic                    legal;
    evClass_t                pushClass;
    ctxState_t               ctxNext;
    logic [CNT_W-1:0]        ctxCnt;
    logic                    full, pop, push, dropNext;

    assign press   = validPress & ~prevPress;
    assign isDigit = (button <= KEY_W'(9));
    assign isMinus = (button == KEY_W'(11));
    assign isOp    = (button == KEY_W'(10)) || (button == KEY_W'(12)) || (button == KEY_W'(13));
    assign isEqual = (button == KEY_W'(14));
    assign isClear = (button == KEY_W'(15));

    assign clearPress = press & isClear;
    assign ev_valid   = (count != '0);
    assign full       = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign pop        = ev_valid & ev_ready;

    // Context classification: decides whether a press is legal here and what it becomes.
    always_comb begin
        legal     = 1'b0;
        pushClass = CLS_NONE;
        ctxNext   = state;
        ctxCnt    = digitCnt;
        if (press && !isClear) begin
            if (isDigit) begin
                if (state == IN_OP) begin
                    if (digitCnt < CNT_W'(MAX_DIGITS)) begin
                        legal     = 1'b1;
                        pushClass = CLS_NUMBER;
                        ctxCnt    = digitCnt + CNT_W'(1);
                    end
                end else begin
                    legal     = 1'b1;
                    pushClass = CLS_NUMBER;
                    ctxNext   = IN_OP;
                    ctxCnt    = CNT_W'(1);
                end
            end else if (isMinus) begin
                case (state)
                    START, AFTER_OP: begin
                        legal     = 1'b1;
                        pushClass = CLS_NEGATIVE;
                        ctxNext   = NEG;
                        ctxCnt    = '0;
                    end
                    IN_OP, RESULT: begin
                        legal     = 1'b1;
                        pushClass = CLS_OPER;
                        ctxNext   = AFTER_OP;
                        ctxCnt    = '0;
                    end
                    default: ;
                endcase
            end else if (isOp) begin
                if (state == IN_OP || state == RESULT) begin
                    legal     = 1'b1;
                    pushClass = CLS_OPER;
                    ctxNext   = AFTER_OP;
                    ctxCnt    = '0;
                end
            end else if (isEqual) begin
                if (state == IN_OP) begin
                    legal     = 1'b1;
                    pushClass = CLS_EQUAL;
                    ctxNext   = RESULT;
                    ctxCnt    = '0;
                end
            end
        end
    end

    // A legal press still loses if the FIFO is full and nothing leaves this cycle.
    always_comb begin
        push         = legal & (~full | pop);
        dropNext     = press & ~isClear & ~push;
        stateNext    = state;
        digitCntNext = digitCnt;
        if (clearPress) begin
            stateNext    = START;
            digitCntNext = '0;
        end else if (push) begin
            stateNext    = ctxNext;
            digitCntNext = ctxCnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= START;
            digitCnt <= '0;
        end else begin
            state    <= stateNext;
            digitCnt <= digitCntNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prevPress <= 1'b0;
            drop      <= 1'b0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
        end else begin
            prevPress <= validPress;
            drop      <= dropNext;
            if (clearPress) begin
                rdPtr <= '0;
                wrPtr <= PTR_W'(1);
                count <= ($clog2(DEPTH)+1)'(1);
            end else begin
                if (push)
                    wrPtr <= wrPtr + PTR_W'(1);
                if (pop)
                    rdPtr <= rdPtr + PTR_W'(1);
                if (push && !pop)
                    count <= count + ($clog2(DEPTH)+1)'(1);
                else if (pop && !push)
                    count <= count - ($clog2(DEPTH)+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clearPress)
            mem[0] <= {CLS_CLEAR, button};
        else if (push)
            mem[wrPtr] <= {pushClass, button};
    end

    assign fifo_count = count;
    assign ev_class   = ev_valid ? mem[rdPtr][ENT_W-1:KEY_W] : 3'd0;
    assign ev_code    = ev_valid ? mem[rdPtr][KEY_W-1:0] : '0;

endmodule
